// File: rtl/ch_aline_pkg.sv
// Shared definitions for the A-line buffer and its readers: buffer geometry
// and the read-engine FSM state encoding.
package ch_aline_pkg;

  localparam int ALINE_ADDR_W = 5;   // buffer depth = 2**ALINE_ADDR_W
  localparam int ALINE_DATA_W = 8;   // sample width
  localparam int ALINE_LEN_W  = 6;   // length field, wide enough for a full buffer

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } aline_state_e;

endpackage

// File: rtl/ch_aline_out_reg.sv
// Valid/ready output register for the A-line reader. Holds data and last
// steady while the consumer stalls; reports when it can take a new beat and
// when the current beat is being accepted.
module ch_aline_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              can_load_o,
  output logic              hshake_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  assign can_load_o = !valid_q || ready_i;
  assign hshake_o   = valid_q && ready_i;
  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign last_o     = last_q;

  // Next-state: a load replaces the beat, a clear retires it, otherwise hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
      last_d  = last_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Output beat register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/ch_aline_reader.sv
// Read-side engine for the A-line LUT-RAM buffer: walks the buffer from a
// base address for a programmed length and streams the samples on a
// valid/ready interface with a last flag.
// Optional build macro CH_ALINE_CHECKSUM_EN appends a modulo-2**DATA_W sum
// of the streamed samples as one extra beat carrying m_last.
module ch_aline_reader
  import ch_aline_pkg::*;
#(
  parameter int ADDR_W = ALINE_ADDR_W,
  parameter int DATA_W = ALINE_DATA_W,
  parameter int LEN_W  = ALINE_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Requests longer than the buffer read it exactly once round.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(DEPTH)) return LEN_W'(DEPTH);
    return len;
  endfunction

  aline_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  len_sat;

  logic              ld;
  logic              clr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              can_load;
  logic              hshake;

`ifdef CH_ALINE_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign len_sat  = sat_len(length);
  assign ram_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // FSM next-state, address/length counters and output-register control.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ld      = 1'b0;
    clr     = 1'b0;
    ld_data = ram_data;
    ld_last = 1'b0;
`ifdef CH_ALINE_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef CH_ALINE_CHECKSUM_EN
          sum_d = '0;
`endif
          if (len_sat != '0) begin
            addr_d  = base_addr;
            rem_d   = len_sat;
            busy_d  = 1'b1;
            state_d = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (can_load) begin
          ld = 1'b1;
`ifdef CH_ALINE_CHECKSUM_EN
          // rem_q reaching zero inside FETCH marks the checksum beat.
          if (rem_q == '0) begin
            ld_data = sum_q;
            ld_last = 1'b1;
            state_d = DRAIN;
          end else begin
            sum_d  = sum_q + ram_data;
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
          end
`else
          ld_last = (rem_q == LEN_W'(1));
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
`endif
        end
      end
      DRAIN: begin
        if (hshake && m_last) begin
          clr     = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef CH_ALINE_CHECKSUM_EN
  // Running checksum of the samples streamed in the current readout.
  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end
`endif

  ch_aline_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ld),
    .clear_i   (clr),
    .data_i    (ld_data),
    .last_i    (ld_last),
    .ready_i   (m_ready),
    .data_o    (m_data),
    .valid_o   (m_valid),
    .last_o    (m_last),
    .can_load_o(can_load),
    .hshake_o  (hshake)
  );

endmodule

// File: tb/tb_ch_aline_reader.sv
// Self-checking bench for ch_aline_reader: behavioural buffer, scoreboard of
// expected beats, negedge monitor.
module tb_ch_aline_reader;

`ifdef CH_ALINE_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] length;
  logic [4:0] ram_addr;
  logic [7:0] ram_data;
  logic       busy;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       done;

  logic [7:0] mem [32];
  logic [8:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int first_cyc, last_beat_cyc, done_cyc;
  logic arm_first = 1'b0;
  logic busy_seen = 1'b0;
  logic stall_q = 1'b0;
  logic [7:0] held_data;
  logic held_last;

  assign ram_data = mem[ram_addr];

  ch_aline_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .busy     (busy),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: scoreboard compare on handshake, stall stability, done count.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (stall_q) begin
        check_val("stall_valid", {31'd0, m_valid}, 32'd1);
        check_val("stall_data", {24'd0, m_data}, {24'd0, held_data});
        check_val("stall_last", {31'd0, m_last}, {31'd0, held_last});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_val("beat_data", {24'd0, m_data}, {24'd0, e[7:0]});
          check_val("beat_last", {31'd0, m_last}, {31'd0, e[8]});
        end
        beat_cnt++;
        last_beat_cyc = cyc_cnt;
        if (arm_first) begin
          first_cyc = cyc_cnt;
          arm_first = 1'b0;
        end
      end
      stall_q   = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
      end
      if (busy) busy_seen = 1'b1;
    end else begin
      stall_q = 1'b0;
    end
  end

  // One readout: push expectations, pulse start, run until done or budget.
  // rmode 0 = m_ready high, 1 = m_ready pattern 1,0,0. restart_at >= 0
  // pulses a second start while busy.
  task automatic run_readout(input int base, input int len, input int rmode,
                             input int restart_at, output int s_cyc);
    int n, beats0, done0, cyc;
    logic [7:0] d, sum;
    n   = (len > 32) ? 32 : len;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      d = mem[(base + i) % 32];
      sum = sum + d;
      exp_q.push_back({(i == n - 1) && (CS == 0), d});
    end
    if (CS == 1 && n != 0) begin
      exp_q.push_back({1'b1, sum});
      n++;
    end
    beats0    = beat_cnt;
    done0     = done_cnt;
    busy_seen = 1'b0;
    arm_first = 1'b1;
    start     = 1'b1;
    base_addr = 5'(base);
    length    = 6'(len);
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc_cnt;
    cyc   = 0;
    while (done_cnt == done0 && cyc < 400) begin
      m_ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (cyc == restart_at) begin
        start     = 1'b1;
        base_addr = 5'd3;
        length    = 6'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    if (cyc >= 400) check_val("timeout", 32'(cyc), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("beat_count", 32'(beat_cnt - beats0), 32'(n));
    check_val("done_count", 32'(done_cnt - done0), 32'd1);
    check_val("busy_after", {31'd0, busy}, 32'd0);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    check_val("busy_seen", {31'd0, busy_seen}, (len == 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    int s, beats0, done0, cyc;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 16);
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ram_addr", {27'd0, ram_addr}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_m_data", {24'd0, m_data}, 32'd0);
    check_val("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check_val("rst_m_last", {31'd0, m_last}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full buffer, back-to-back beats, latency and done timing.
    run_readout(0, 32, 0, -1, s);
    check_val("first_latency", 32'(first_cyc), 32'(s + 1));
    check_val("burst_span", 32'(last_beat_cyc - first_cyc), 32'(31 + CS));
    check_val("done_timing", 32'(done_cyc), 32'(last_beat_cyc + 1));

    // Address wrap 31 -> 0.
    run_readout(30, 4, 0, -1, s);

    // Backpressure pattern.
    run_readout(0, 8, 1, -1, s);

    // Second start while busy is ignored.
    run_readout(0, 5, 0, 2, s);

    // Reset on the 3rd beat abandons the readout.
    for (int i = 0; i < 10; i++) exp_q.push_back({i == 9 && CS == 0, mem[i]});
    beats0 = beat_cnt;
    done0  = done_cnt;
    start = 1'b1; base_addr = 5'd0; length = 6'd10;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while ((beat_cnt - beats0) < 3 && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    check_val("rst_wait_timeout", 32'(beat_cnt - beats0), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check_val("midrst_no_done", 32'(done_cnt - done0), 32'd0);
    check_val("midrst_no_beats", 32'(beat_cnt - beats0), 32'd3);
    run_readout(0, 2, 0, -1, s);

    // Zero length: no beats, one done, never busy.
    run_readout(0, 0, 0, -1, s);

    // Oversized length saturates to one full buffer pass.
    run_readout(5, 40, 0, -1, s);

`ifdef CH_ALINE_CHECKSUM_EN
    mem[0] = 8'hFF; mem[1] = 8'h02; mem[2] = 8'h01;
    run_readout(0, 3, 0, -1, s);
    run_readout(0, 3, 1, -1, s);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ch_aline_reader.md
Name: ch_aline_reader

Overview:
Read-side engine for the 32x8 A-line LUT-RAM buffer. On a start pulse it walks the buffer from a base address for a programmed length, presents the address, and captures the asynchronous-read data. It streams the samples out on a valid/ready interface with a last flag. It sits between the A-line storage and the downstream serializer/host link; the top level grants it the buffer's shared address port while busy is high.

Parameters:
ADDR_W, 5, buffer address width (depth = 2**ADDR_W = 32)
DATA_W, 8, sample width
LEN_W, 6, width of length input (must hold 2**ADDR_W)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a readout; ignored while busy
base_addr  input  ADDR_W  first buffer address, sampled on accepted start
length  input  LEN_W  sample count, sampled on accepted start; 0 = no-op
ram_addr  output  ADDR_W  address to the buffer's shared addr port
ram_data  input  DATA_W  buffer data_out (combinational read of ram_addr)
busy  output  1  high from accepted start until the final beat is accepted; top level must hold the buffer's wr_en low while busy
m_data  output  DATA_W  streamed sample
m_valid  output  1  m_data valid
m_ready  input  1  downstream accept
m_last  output  1  qualifies the final beat of a readout
done  output  1  one-cycle pulse after the final beat handshake

Behaviour:
- Reset values: ram_addr=0, busy=0, m_data=0, m_valid=0, m_last=0, done=0; FSM to IDLE; internal counters cleared. A reset mid-readout abandons the transfer with no done pulse.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE: start=1 with length!=0 -> latch base_addr into ram_addr and length into remaining; busy=1; go to FETCH. start=1 with length=0 -> done pulses next cycle; busy stays 0; remain in IDLE.
- FETCH: the output register loads when (!m_valid || m_ready). On load: m_data<=ram_data, m_valid<=1, m_last<=(remaining==1), ram_addr<=ram_addr+1 (mod 2**ADDR_W, wrap 31->0), remaining<=remaining-1. When remaining==1 loads, go to DRAIN.
- DRAIN: hold until m_valid && m_ready && m_last. Then m_valid<=0, m_last<=0, busy<=0, done<=1 for one cycle; go to IDLE.
- Throughput: one beat per cycle with m_ready held high. The first m_valid asserts 2 cycles after the start cycle (start edge, then load edge).
- m_data, m_valid, and m_last are stable while m_valid && !m_ready (AXI-style, no retraction).
- start while busy is ignored and is not queued. A start in the same cycle as done is accepted (FSM is in IDLE).
- length > 2**ADDR_W is saturated to 2**ADDR_W. Wrap-around reads continue from address 0.

Optional Feature:
Macro CH_ALINE_CHECKSUM_EN.
- Defined: a DATA_W-bit modulo-2**DATA_W sum of all streamed samples is appended as one extra beat after the last sample. m_last moves to the checksum beat, the sum clears on accepted start, and length=0 yields no beats.
- Undefined: no checksum logic; beat count equals length.

Decomposition:
- Shared package ch_aline_pkg: ADDR_W/DATA_W/LEN_W constants (shared with ch_aline_storage users) and the FSM state enum (IDLE/FETCH/DRAIN).
- One natural sub-module: ch_aline_out_reg, the valid/ready output register holding data/last under backpressure. The FSM and address counter stay in the top.

Test Plan:
- Buffer preloaded with mem[i]=i+8'h10; start base=0 len=32, m_ready=1 -> 32 beats 8'h10..8'h2F on consecutive cycles, m_last on beat 32, done one cycle later, busy low after.
- base=30 len=4 -> beats mem[30],mem[31],mem[0],mem[1] (address wrap); m_last on the 4th.
- len=8 with m_ready toggling 1,0,0,1,... -> m_data held constant during stalls; no beat dropped or duplicated; order 0..7.
- start pulsed again mid-readout (len=5) -> ignored; exactly 5 beats; a single done.
- rst asserted on the 3rd beat of a len=10 readout -> next cycle m_valid=0, busy=0, no done; a fresh start base=0 len=2 then yields mem[0],mem[1].
- len=0 -> no beats, done pulses once, busy stays 0. With CH_ALINE_CHECKSUM_EN and len=3 of 8'hFF,8'h02,8'h01 -> 4th beat 8'h02 with m_last.
